gray_code_counter: RTL



---
 rtl/gray_pkg.sv | 34 +++
 rtl/gray_to_binary_reg.sv | 33 +++
 rtl/gray_code_counter.sv | 69 ++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and its conversion channel.
// Functions work on a 32-bit container; callers zero-extend narrower words and
// truncate the result back to their own width.
package gray_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef logic [MaxWidth-1:0] word_t;

  // Binary to Gray: each Gray bit marks a change between adjacent binary bits.
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down, limited to the low 'width' bits.
  function automatic word_t gray2bin(input word_t g, input int unsigned width);
    word_t mask;
    word_t gm;
    word_t b;
    if (width >= MaxWidth) begin
      mask = '1;
    end else begin
      mask = (word_t'(1) << width) - word_t'(1);
    end
    gm = g & mask;
    b = '0;
    b[MaxWidth-1] = gm[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary_reg.sv
// Registered Gray-to-binary converter: one word per cycle, one cycle of latency.
// The result register only updates on valid input so it holds the last answer.
module gray_to_binary_reg
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_word,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_word,
  output logic             bin_valid
);

  logic [WIDTH-1:0] bin_next;

  assign bin_next = WIDTH'(gray2bin(word_t'(gray_word), WIDTH));

  // Capture the converted word on valid input and delay the valid flag by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_word  <= '0;
      bin_valid <= 1'b0;
    end else begin
      bin_valid <= gray_valid;
      if (gray_valid) begin
        bin_word <= bin_next;
      end
    end
  end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down Gray-code counter with a binary shadow count, a registered wrap pulse
// and an independent registered Gray-to-binary conversion channel.
// The count lives in binary; gray_q is its own register loaded from the encoded
// next value, so the Gray output never glitches.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_BIN = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             wrap,
  input  logic [WIDTH-1:0] conv_gray_in,
  input  logic             conv_valid_in,
  output logic [WIDTH-1:0] conv_bin_out,
  output logic             conv_valid_out
);

  localparam logic [WIDTH-1:0] ResetGray = WIDTH'(bin2gray(word_t'(RESET_BIN)));

  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             step_wraps;

  // Modulo-2^WIDTH step; wraps exactly when stepping off either end of the range.
  assign bin_step   = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
  assign step_wraps = up ? (&bin_q) : ~(|bin_q);
  assign next_bin   = load ? load_bin : bin_step;
  assign next_gray  = WIDTH'(bin2gray(word_t'(next_bin)));

  // Count state: load beats enable; load and hold both clear the wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_BIN;
      gray_q <= ResetGray;
      wrap   <= 1'b0;
    end else if (load) begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap   <= 1'b0;
    end else if (en) begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap   <= step_wraps;
    end else begin
      wrap   <= 1'b0;
    end
  end

  gray_to_binary_reg #(
    .WIDTH (WIDTH)
  ) u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_word  (conv_gray_in),
    .gray_valid (conv_valid_in),
    .bin_word   (conv_bin_out),
    .bin_valid  (conv_valid_out)
  );

endmodule
